round_timer_ctrl: RTL and testbench

Round-sequencing controller for the rock-paper-scissors game, built on a shared clock prescaler. It owns one free-running millisecond prescaler and derives a one-second tick from it. Both ticks go to display scan, debounce and blink logic. On request it runs the round: countdown, one-cycle reveal strobe for latching player choices, result hold, then back to idle. It replaces ad-hoc per-consumer divided clocks with single-clock-domain enable ticks.

---
 rtl/round_timer_ctrl.sv | 118 +++++++++++
 tb/tb_round_timer_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/round_timer_ctrl.sv
// Round sequencer for rock-paper-scissors: shared 1 ms / 1 s enable ticks plus countdown -> reveal -> hold.
// Latency: outputs registered or decoded from state; start/abort act on the next clk edge.
// Backpressure: none; start while busy is dropped, abort always wins over start and ticks.
module round_timer_ctrl #(
  parameter int DIV_MS      = 50_000,
  parameter int MS_PER_SEC  = 1000,
  parameter int COUNT_START = 3,
  parameter int HOLD_SEC    = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  output logic       tick_1ms,
  output logic       tick_1s,
  output logic [3:0] count_val,
  output logic [1:0] phase,
  output logic       busy,
  output logic       reveal,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COUNT  = 2'd1,
    REVEAL = 2'd2,
    HOLD   = 2'd3
  } phase_t;

  localparam int MS_W  = (DIV_MS > 2) ? $clog2(DIV_MS) : 1;
  localparam int SEC_W = (MS_PER_SEC > 2) ? $clog2(MS_PER_SEC) : 1;
  localparam logic [MS_W-1:0]  MS_LAST    = MS_W'(DIV_MS - 1);
  localparam logic [SEC_W-1:0] SEC_LAST   = SEC_W'(MS_PER_SEC - 1);
  localparam logic [3:0]       COUNT_INIT = 4'(COUNT_START);
  localparam logic [3:0]       HOLD_INIT  = 4'(HOLD_SEC);

  logic [MS_W-1:0]  ms_cnt;
  logic [SEC_W-1:0] sec_cnt;
  logic [3:0]       hold_cnt;
  logic             start_ok;
  phase_t           state;

  assign tick_1ms = (ms_cnt == MS_LAST);
  assign tick_1s  = tick_1ms & (sec_cnt == SEC_LAST);
  assign start_ok = start & ~abort & (state == IDLE);
  assign phase    = state;
  assign busy     = (state != IDLE);
  assign reveal   = (state == REVEAL);

  // Accepted start resyncs the prescaler so the first countdown second is exact.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ms_cnt  <= '0;
      sec_cnt <= '0;
    end else if (start_ok) begin
      ms_cnt  <= '0;
      sec_cnt <= '0;
    end else if (tick_1ms) begin
      ms_cnt  <= '0;
      sec_cnt <= (sec_cnt == SEC_LAST) ? '0 : sec_cnt + SEC_W'(1);
    end else begin
      ms_cnt  <= ms_cnt + MS_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      count_val <= 4'd0;
      hold_cnt  <= 4'd0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort && state != IDLE) begin
        state     <= IDLE;
        count_val <= 4'd0;
        hold_cnt  <= 4'd0;
      end else begin
        case (state)
          IDLE: begin
            if (start_ok) begin
              state     <= COUNT;
              count_val <= COUNT_INIT;
            end
          end
          COUNT: begin
            if (tick_1s) begin
              if (count_val > 4'd1) begin
                count_val <= count_val - 4'd1;
              end else begin
                state     <= REVEAL;
                count_val <= 4'd0;
              end
            end
          end
          REVEAL: begin
            state    <= HOLD;
            hold_cnt <= HOLD_INIT;
          end
          HOLD: begin
            // Prescaler is not resynced here, so the first hold second runs one cycle short.
            if (tick_1s) begin
              if (hold_cnt > 4'd1) begin
                hold_cnt <= hold_cnt - 4'd1;
              end else begin
                state    <= IDLE;
                hold_cnt <= 4'd0;
                done     <= 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_round_timer_ctrl.sv
// Bench for round_timer_ctrl (DIV_MS=4, MS_PER_SEC=5): expected output changes and ticks
// are queued with hand-computed cycle numbers; negedge monitors pop and compare.
module tb_round_timer_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       tick_1ms, tick_1s, busy, reveal, done;
  logic [3:0] count_val;
  logic [1:0] phase;

  round_timer_ctrl #(
    .DIV_MS(4), .MS_PER_SEC(5), .COUNT_START(3), .HOLD_SEC(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .tick_1ms(tick_1ms), .tick_1s(tick_1s), .count_val(count_val),
    .phase(phase), .busy(busy), .reveal(reveal), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [1:0] ph;
    logic [3:0] cv;
    logic       rv;
    logic       dn;
  } ev_t;

  typedef struct {
    int   cyc;
    logic s;
  } tk_t;

  ev_t  evq[$];
  tk_t  tkq[$];
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  bit   tick_chk = 1'b0;
  logic [8:0] prev = '0;
  logic [8:0] snap;
  logic [8:0] want;
  ev_t  e;
  tk_t  t;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: every change of the visible round state is one expected event.
  always @(negedge clk) begin
    if (tick_chk && tick_1ms) begin
      tests++;
      if (tkq.size() == 0) begin
        fails++;
        $display("FAIL tick: unexpected tick_1ms at cycle %0d (tick_1s=%0b)", cyc, tick_1s);
      end else begin
        t = tkq.pop_front();
        if (t.cyc != cyc || t.s !== tick_1s) begin
          fails++;
          $display("FAIL tick: got cycle %0d tick_1s=%0b, expected cycle %0d tick_1s=%0b",
                   cyc, tick_1s, t.cyc, t.s);
        end
      end
    end
    snap = {phase, count_val, reveal, done, busy};
    if (snap !== prev) begin
      tests++;
      if (evq.size() == 0) begin
        fails++;
        $display("FAIL event: unexpected change at cycle %0d phase=%0d cnt=%0d rev=%0b done=%0b busy=%0b",
                 cyc, phase, count_val, reveal, done, busy);
      end else begin
        e = evq.pop_front();
        want = {e.ph, e.cv, e.rv, e.dn, (e.ph != 2'd0)};
        if (e.cyc != cyc || snap !== want) begin
          fails++;
          $display("FAIL event: got cycle %0d phase=%0d cnt=%0d rev=%0b done=%0b busy=%0b, expected cycle %0d phase=%0d cnt=%0d rev=%0b done=%0b busy=%0b",
                   cyc, phase, count_val, reveal, done, busy,
                   e.cyc, e.ph, e.cv, e.rv, e.dn, (e.ph != 2'd0));
        end
      end
      prev = snap;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) step();
  endtask

  task automatic push_ev(input int c, input logic [1:0] ph, input logic [3:0] cv,
                         input logic rv, input logic dn);
    ev_t x;
    x.cyc = c; x.ph = ph; x.cv = cv; x.rv = rv; x.dn = dn;
    evq.push_back(x);
  endtask

  task automatic push_tk(input int c, input logic s);
    tk_t x;
    x.cyc = c; x.s = s;
    tkq.push_back(x);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " phase"}, 32'(phase), 32'd0);
    chk({tag, " count_val"}, 32'(count_val), 32'd0);
    chk({tag, " busy"}, 32'(busy), 32'd0);
    chk({tag, " reveal"}, 32'(reveal), 32'd0);
    chk({tag, " done"}, 32'(done), 32'd0);
    chk({tag, " tick_1ms"}, 32'(tick_1ms), 32'd0);
    chk({tag, " tick_1s"}, 32'(tick_1s), 32'd0);
  endtask

  // Issues a one-cycle start; returns the accepting edge E0 with the COUNT=3 event queued.
  task automatic start_round(output int e0);
    step();
    start = 1'b1;
    e0 = cyc + 1;
    push_ev(e0, 2'd1, 4'd3, 1'b0, 1'b0);
    step();
    start = 1'b0;
  endtask

  task automatic full_round(input bit poke_hold);
    int e0;
    start_round(e0);
    push_ev(e0 + 20,  2'd1, 4'd2, 1'b0, 1'b0);
    push_ev(e0 + 40,  2'd1, 4'd1, 1'b0, 1'b0);
    push_ev(e0 + 60,  2'd2, 4'd0, 1'b1, 1'b0);
    push_ev(e0 + 61,  2'd3, 4'd0, 1'b0, 1'b0);
    push_ev(e0 + 100, 2'd0, 4'd0, 1'b0, 1'b1);
    push_ev(e0 + 101, 2'd0, 4'd0, 1'b0, 1'b0);
    if (poke_hold) begin
      wait_until(e0 + 69);
      start = 1'b1;
      step();
      start = 1'b0;
    end
    wait_until(e0 + 105);
  endtask

  initial begin
    int e0;
    int c;
    #1 rst_n = 1'b0;

    // 1. Reset state and free-running prescaler
    step();
    step();
    chk_all_zero("reset");
    c = cyc;
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) push_tk(c + 3 + 4 * k, (k % 5) == 4);
    tick_chk = 1'b1;
    wait_until(c + 41);
    tick_chk = 1'b0;

    // 2. Full round
    full_round(1'b0);

    // 3. Abort while count_val=2, then a fresh full round
    start_round(e0);
    push_ev(e0 + 20, 2'd1, 4'd2, 1'b0, 1'b0);
    push_ev(e0 + 26, 2'd0, 4'd0, 1'b0, 1'b0);
    wait_until(e0 + 25);
    abort = 1'b1;
    step();
    abort = 1'b0;
    wait_until(e0 + 30);
    full_round(1'b0);

    // 4a. Start pulse during HOLD is ignored
    full_round(1'b1);

    // 4b. Start together with abort in IDLE is rejected
    step();
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    repeat (10) step();
    chk("start+abort phase", 32'(phase), 32'd0);
    chk("start+abort busy", 32'(busy), 32'd0);

    // 4c. Abort on the tick_1s edge that would reveal
    start_round(e0);
    push_ev(e0 + 20, 2'd1, 4'd2, 1'b0, 1'b0);
    push_ev(e0 + 40, 2'd1, 4'd1, 1'b0, 1'b0);
    push_ev(e0 + 60, 2'd0, 4'd0, 1'b0, 1'b0);
    wait_until(e0 + 59);
    chk("pre-abort tick_1s", 32'(tick_1s), 32'd1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    wait_until(e0 + 70);

    // 5. Async reset mid-HOLD, then prescaler restart
    start_round(e0);
    push_ev(e0 + 20, 2'd1, 4'd2, 1'b0, 1'b0);
    push_ev(e0 + 40, 2'd1, 4'd1, 1'b0, 1'b0);
    push_ev(e0 + 60, 2'd2, 4'd0, 1'b1, 1'b0);
    push_ev(e0 + 61, 2'd3, 4'd0, 1'b0, 1'b0);
    wait_until(e0 + 70);
    chk("mid-hold phase", 32'(phase), 32'd3);
    push_ev(e0 + 71, 2'd0, 4'd0, 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    #1 chk_all_zero("async reset");
    wait_until(e0 + 75);
    c = cyc;
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) push_tk(c + 3 + 4 * k, k == 4);
    tick_chk = 1'b1;
    wait_until(c + 21);
    tick_chk = 1'b0;

    repeat (3) step();
    tests++;
    if (evq.size() != 0) begin
      fails++;
      $display("FAIL events missing: got %0d left in queue, expected 0 (next at cycle %0d)",
               evq.size(), evq[0].cyc);
    end
    tests++;
    if (tkq.size() != 0) begin
      fails++;
      $display("FAIL ticks missing: got %0d left in queue, expected 0 (next at cycle %0d)",
               tkq.size(), tkq[0].cyc);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
